axis_packet_arbiter: RTL and testbench
======================================

Name: axis_packet_arbiter

Overview:
- Shares one AXI4-Stream packet sink (the downstream packet/UDP sender) between NUM_SRC packet sources, e.g. several frame-packing controllers each emitting 112-bit beats.
- Grants whole packets, delimited by tlast, using round-robin priority.
- Enforces a programmable idle gap between consecutive packets on the master side.
- Counts completed packets for status readout.

Parameters:
- NUM_SRC, 4, number of slave stream sources (2..8).
- DATA_WIDTH, 112, beat width in bits.
- CNTR_WIDTH, 32, width of the gap counter and the packet counter.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous, active-high reset.
- cfg_data  input  CNTR_WIDTH  idle gap, in cycles, inserted after each packet.
- cfg_mask  input  NUM_SRC  per-source enable; 1 = eligible for grant.
- sts_data  output  CNTR_WIDTH  completed-packet count, wraps.
- sts_grant  output  NUM_SRC  one-hot currently granted source; all zero when not in GRANT.
- s_axis_tdata  input  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  input  NUM_SRC  per-source valid.
- s_axis_tlast  input  NUM_SRC  per-source end of packet.
- s_axis_tready  output  NUM_SRC  per-source ready.
- m_axis_tdata  output  DATA_WIDTH  forwarded beat.
- m_axis_tvalid  output  1  forwarded valid.
- m_axis_tlast  output  1  forwarded last.
- m_axis_tready  input  1  downstream ready.

Behaviour:
- Reset (areset=1 at a rising edge) forces, on that edge:
  - state IDLE, grant index 0, round-robin pointer 0, gap counter 0, sts_data 0;
  - sts_grant 0, m_axis_tvalid 0, m_axis_tlast 0, s_axis_tready all 0;
  - m_axis_tdata is don't-care, but the bench expects 0.
- Reset mid-packet aborts the packet immediately; no partial-packet cleanup.
- States: IDLE, GRANT, GAP.
- IDLE:
  - request vector = s_axis_tvalid & cfg_mask.
  - If nonzero, select the first set bit searching from the pointer upward, wrapping modulo NUM_SRC.
  - Register it as the grant index and go to GRANT.
  - Arbitration takes 1 cycle; the first beat can transfer the cycle after the request is seen.
  - With no request, stay in IDLE.
- GRANT (combinational pass-through, no data register):
  - m_axis_tdata/tvalid/tlast = selected source's tdata/tvalid/tlast.
  - s_axis_tready[g] = m_axis_tready; all other tready bits = 0.
  - sts_grant = one-hot(g).
  - A beat transfers when m_axis_tvalid & m_axis_tready.
  - On a transfer with tlast=1: sts_data increments (wraps at 2^CNTR_WIDTH), pointer becomes (g+1) mod NUM_SRC, and cfg_data is sampled.
  - If the sampled cfg_data = 0, go to IDLE; otherwise load the gap counter with cfg_data and go to GAP.
- GAP:
  - All tready and m_axis_tvalid are 0.
  - Gap counter decrements each cycle; when it reaches 1, go to IDLE.
  - A gap of cfg_data=N gives exactly N cycles in GAP and N+1 dead cycles between the last beat and the next first beat (including the IDLE arbitration cycle).
- Within a packet:
  - cfg_mask changes do not affect an active grant; the mask is evaluated only in IDLE.
  - Source tvalid deassertion is a bubble: m_axis_tvalid follows it low and the grant is held until tlast.
  - A packet has no length limit; a source that never asserts tlast holds the bus indefinitely. This is the intended behaviour.
- Fairness: after source g completes, g has the lowest priority at the next arbitration.
- A single requesting source is re-granted after every packet plus gap.
- cfg_mask = 0 means permanent IDLE; no tready is ever asserted.
- Slave tdata is ignored unless tvalid.
- The master never asserts tvalid outside GRANT.

Test Plan:
1. Reset, then only source 2 valid with a 3-beat packet (tlast on beat 3), cfg_data=0, m_axis_tready=1:
   - arbitration 1 cycle, then 3 consecutive transfers with data and tlast from source 2;
   - sts_grant=4'b0100 during the packet; sts_data=1 afterwards.
2. All 4 sources continuously valid, 1-beat packets, cfg_mask=4'hF, cfg_data=0:
   - grant order 0,1,2,3,0,1;
   - transfers every 2nd cycle; sts_data=6 after 12 cycles.
3. cfg_data=5, two back-to-back packets from source 1:
   - exactly 6 cycles with m_axis_tvalid=0 between the first packet's last beat and the second packet's first beat.
4. m_axis_tready toggles 1,0,1,0 and source 0 drops tvalid for 2 cycles mid-packet:
   - no beat lost or duplicated; s_axis_tready[0] mirrors m_axis_tready; the grant holds until tlast.
5. cfg_mask=4'b1010 with all sources valid:
   - only sources 1 and 3 are ever granted, alternating.
   - Clearing bit 1 mid-packet from source 1 still completes that packet.
6. areset asserted on the 2nd beat of a 4-beat packet:
   - next cycle all tready=0, m_axis_tvalid=0, sts_grant=0, sts_data=0;
   - after release, arbitration restarts from source 0.

Source files
------------

// File: rtl/axis_packet_arbiter_if.sv
// AXI4-Stream bundle. LANES > 1 carries several parallel streams side by side,
// with lane i in tdata[i*DATA_WIDTH +: DATA_WIDTH].
interface axis_packet_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 112
) ();
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tready;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: grants whole tlast-delimited packets from NUM_SRC
// sources to one sink, inserts a programmable idle gap, and counts packets.
module axis_packet_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 112,
    parameter int CNTR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    input  logic [NUM_SRC-1:0]    cfg_mask,
    output logic [CNTR_WIDTH-1:0] sts_data,
    output logic [NUM_SRC-1:0]    sts_grant,
    axis_packet_arbiter_if.slave  s_axis,
    axis_packet_arbiter_if.master m_axis
);
    localparam int IDX_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_t;

    state_t                  state_reg;
    logic [IDX_W-1:0]        grant_reg;
    logic [IDX_W-1:0]        ptr_reg;
    logic [CNTR_WIDTH-1:0]   gap_reg;
    logic [CNTR_WIDTH-1:0]   pkt_cnt_reg;
    logic [NUM_SRC-1:0]      grant_oh_reg;

    logic [DATA_WIDTH-1:0]   lane_data [NUM_SRC];
    logic [NUM_SRC-1:0]      req;
    logic                    pick_valid;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand_idx;
    logic                    in_grant;
    logic                    xfer_last;

    assign in_grant = (state_reg == ST_GRANT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
            assign lane_data[gi]      = s_axis.tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign s_axis.tready[gi]  = in_grant && (grant_reg == IDX_W'(gi)) && m_axis.tready[0];
        end
    endgenerate

    // Pure pass-through while granted; the sink sees the source's own bubbles.
    assign m_axis.tdata     = in_grant ? lane_data[grant_reg] : '0;
    assign m_axis.tvalid[0] = in_grant && s_axis.tvalid[grant_reg];
    assign m_axis.tlast[0]  = in_grant && s_axis.tlast[grant_reg];
    assign xfer_last        = m_axis.tvalid[0] && m_axis.tready[0] && m_axis.tlast[0];

    assign sts_data  = pkt_cnt_reg;
    assign sts_grant = grant_oh_reg;

    // Scan from the highest offset down so the closest requester above ptr wins.
    always_comb begin
        req        = s_axis.tvalid & cfg_mask;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand_idx = IDX_W'((int'(ptr_reg) + k) % NUM_SRC);
            if (req[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= '0;
            ptr_reg      <= '0;
            gap_reg      <= '0;
            pkt_cnt_reg  <= '0;
            grant_oh_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_idx;
                        grant_oh_reg <= NUM_SRC'(1) << pick_idx;
                        state_reg    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer_last) begin
                        pkt_cnt_reg  <= pkt_cnt_reg + CNTR_WIDTH'(1);
                        ptr_reg      <= (grant_reg == IDX_W'(NUM_SRC - 1)) ? '0 : grant_reg + IDX_W'(1);
                        grant_oh_reg <= '0;
                        if (cfg_data == '0) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            gap_reg   <= cfg_data;
                            state_reg <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    gap_reg <= gap_reg - CNTR_WIDTH'(1);
                    if (gap_reg == CNTR_WIDTH'(1)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    grant_oh_reg <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter with a rule-level reference model
// (owner, round-robin pointer, earliest-arbitration time, packet count).
module tb_axis_packet_arbiter;
    localparam int NS = 4;
    localparam int DW = 112;
    localparam int CW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic [CW-1:0] cfg_data;
    logic [NS-1:0] cfg_mask;
    logic [CW-1:0] sts_data;
    logic [NS-1:0] sts_grant;

    axis_packet_arbiter_if #(.LANES(NS), .DATA_WIDTH(DW)) s_if ();
    axis_packet_arbiter_if #(.LANES(1),  .DATA_WIDTH(DW)) m_if ();

    axis_packet_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cfg_data  (cfg_data),
        .cfg_mask  (cfg_mask),
        .sts_data  (sts_data),
        .sts_grant (sts_grant),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Source state: current beat data, beats left in packet, beat held unaccepted.
    logic [DW-1:0] cur_data [NS];
    int            cur_left [NS];
    bit            held     [NS];
    bit            vld      [NS];
    logic [NS-1:0] gen_en;
    int            len_min, len_max, valid_pct, ready_pct;
    bit            m_ready;

    // Reference model
    int            mdl_owner;
    int            mdl_ptr;
    int            mdl_arb_at;
    int            mdl_beats;
    logic [CW-1:0] mdl_count;
    bit            after_reset;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        return DW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic drive();
        logic [NS*DW-1:0] td;
        logic [NS-1:0]    tv;
        logic [NS-1:0]    tl;
        for (int i = 0; i < NS; i++) begin
            if (cur_left[i] == 0 && gen_en[i]) begin
                cur_left[i] = $urandom_range(len_max, len_min);
                cur_data[i] = rand_beat();
            end
            vld[i] = (cur_left[i] > 0) && (held[i] || int'($urandom_range(99)) < valid_pct);
            td[i*DW +: DW] = vld[i] ? cur_data[i] : rand_beat();
            tv[i] = vld[i];
            tl[i] = vld[i] ? (cur_left[i] == 1) : 1'($urandom_range(1));
        end
        m_ready     = int'($urandom_range(99)) < ready_pct;
        s_if.tdata  = td;
        s_if.tvalid = tv;
        s_if.tlast  = tl;
        m_if.tready = m_ready;
    endtask

    task automatic check_outputs();
        logic [NS-1:0] exp_grant;
        bit            exp_valid;
        exp_grant = (mdl_owner >= 0) ? (NS'(1) << mdl_owner) : '0;
        exp_valid = (mdl_owner >= 0) && vld[mdl_owner];
        chk("sts_grant", sts_grant, exp_grant);
        chk("s_tready", s_if.tready, m_ready ? exp_grant : '0);
        chk("m_tvalid", m_if.tvalid, exp_valid);
        if (exp_valid) begin
            chk("m_tdata", m_if.tdata, cur_data[mdl_owner]);
            chk("m_tlast", m_if.tlast, cur_left[mdl_owner] == 1);
        end
        chk("sts_data", sts_data, mdl_count);
        if (after_reset) begin
            chk("rst_tdata", m_if.tdata, '0);
            after_reset = 1'b0;
        end
    endtask

    task automatic update();
        int accepted;
        accepted = -1;
        if (areset) begin
            mdl_owner   = -1;
            mdl_ptr     = 0;
            mdl_count   = '0;
            mdl_beats   = 0;
            mdl_arb_at  = cyc + 1;
            after_reset = 1'b1;
            for (int i = 0; i < NS; i++) begin
                cur_left[i] = 0;
                held[i]     = 1'b0;
            end
            return;
        end
        if (mdl_owner >= 0) begin
            if (vld[mdl_owner] && m_ready) begin
                accepted = mdl_owner;
                mdl_beats++;
                if (cur_left[mdl_owner] == 1) begin
                    mdl_count++;
                    $display("pkt src=%0d beats=%0d end_cyc=%0d count=%0d",
                             mdl_owner, mdl_beats, cyc, mdl_count);
                    mdl_ptr    = (mdl_owner + 1) % NS;
                    mdl_arb_at = cyc + 1 + int'(cfg_data);
                    mdl_owner  = -1;
                    mdl_beats  = 0;
                end
            end
        end else if (cyc >= mdl_arb_at) begin
            for (int k = 0; k < NS; k++) begin
                int c;
                c = (mdl_ptr + k) % NS;
                if (vld[c] && cfg_mask[c]) begin
                    mdl_owner = c;
                    break;
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (i == accepted) begin
                cur_left[i]--;
                if (cur_left[i] > 0) cur_data[i] = rand_beat();
                held[i] = 1'b0;
            end else begin
                held[i] = vld[i];
            end
        end
    endtask

    task automatic run_cycle();
        drive();
        #4;
        check_outputs();
        @(posedge aclk);
        #1;
        update();
        cyc++;
    endtask

    task automatic phase(input logic [NS-1:0] gen, input logic [NS-1:0] msk,
                         input int lmin, input int lmax, input int vp, input int rp,
                         input int gap, input int n);
        gen_en    = gen;
        cfg_mask  = msk;
        len_min   = lmin;
        len_max   = lmax;
        valid_pct = vp;
        ready_pct = rp;
        cfg_data  = CW'(gap);
        repeat (n) run_cycle();
    endtask

    initial begin
        bit armed;
        areset    = 1'b1;
        cfg_data  = '0;
        cfg_mask  = '0;
        gen_en    = '0;
        len_min   = 1;
        len_max   = 1;
        valid_pct = 100;
        ready_pct = 100;
        for (int i = 0; i < NS; i++) begin
            cur_left[i] = 0;
            held[i]     = 1'b0;
            vld[i]      = 1'b0;
            cur_data[i] = '0;
        end
        mdl_owner   = -1;
        mdl_ptr     = 0;
        mdl_count   = '0;
        mdl_beats   = 0;
        mdl_arb_at  = 0;
        after_reset = 1'b1;
        s_if.tdata  = '0;
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        m_if.tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        run_cycle();
        areset = 1'b0;

        // Single source 2, 3-beat packets, no gap
        phase(4'b0100, 4'hF, 3, 3, 100, 100, 0, 30);
        // All sources, 1-beat packets: rotation 0,1,2,3 with a transfer every 2nd cycle
        phase(4'hF, 4'hF, 1, 1, 100, 100, 0, 40);
        // Source 1 back-to-back with gap 5
        phase(4'b0010, 4'hF, 1, 3, 100, 100, 5, 60);
        // Source 0 with bubbles and throttled sink
        phase(4'b0001, 4'hF, 4, 8, 60, 50, 0, 150);
        // Mask 1010, then drop source 1 from the mask while it owns the bus
        phase(4'hF, 4'b1010, 2, 5, 100, 80, 1, 150);
        for (int k = 0; k < 200; k++) begin
            if (mdl_owner == 1) break;
            run_cycle();
        end
        chk("mask_wait_owner1", mdl_owner, 1);
        phase(4'hF, 4'b1000, 2, 5, 100, 80, 1, 80);

        // Randomized mixes
        for (int r = 0; r < 8; r++) begin
            int lmin;
            lmin = $urandom_range(3, 1);
            phase(NS'($urandom_range(15, 1)), NS'($urandom_range(15, 1)),
                  lmin, lmin + $urandom_range(5, 0),
                  $urandom_range(100, 40), $urandom_range(100, 30),
                  $urandom_range(4, 0), 200);
        end

        // Reset on the 2nd beat of a 4-beat packet
        phase(4'hF, 4'hF, 4, 4, 100, 100, 0, 10);
        armed = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (mdl_owner >= 0) armed = (cur_left[mdl_owner] == 3);
            if (armed) break;
            run_cycle();
        end
        chk("reset_armed", armed, 1'b1);
        areset = 1'b1;
        run_cycle();
        areset = 1'b0;
        phase(4'hF, 4'hF, 4, 4, 100, 100, 0, 40);

        // Empty mask: nothing is ever granted
        phase(4'hF, 4'h0, 1, 4, 100, 100, 0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
